// File: rtl/seg_pkg.sv
// Shared glyph table, conversion-state encoding and BCD-to-segment decoder
// for the score display.
package seg_pkg;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_COMMIT
  } conv_state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_OFF;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift iteration per clock,
// then a single COMMIT cycle where done pulses and bcd is stable.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int unsigned BIN_W      = 14,
  parameter int unsigned OUT_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [BIN_W-1:0]        bin,
  output logic                    busy,
  output logic [4*OUT_DIGITS-1:0] bcd,
  output logic                    done
);

  localparam int unsigned BCD_W = 4 * OUT_DIGITS;
  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  conv_state_t      state, state_next;
  logic [BIN_W-1:0] bin_sr;
  logic [BCD_W-1:0] bcd_sr;
  logic [BCD_W-1:0] bcd_adj;
  logic [CNT_W-1:0] cnt;

  // Digits above OUT_DIGITS are never kept: carries only travel upward, so
  // the retained low digits stay exact and overflow is saturated upstream.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    bcd_adj = bcd_sr;
    for (int d = 0; d < int'(OUT_DIGITS); d++) begin
      if (bcd_sr[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_sr[4*d +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      CONV_IDLE:   if (load) state_next = CONV_SHIFT;
      CONV_SHIFT:  if (cnt == CNT_W'(BIN_W - 1)) state_next = CONV_COMMIT;
      CONV_COMMIT: state_next = CONV_IDLE;
      default:     state_next = CONV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state  <= CONV_IDLE;
      cnt    <= '0;
      bin_sr <= '0;
      bcd_sr <= '0;
    end else begin
      state <= state_next;
      case (state)
        CONV_IDLE: begin
          if (load) begin
            bin_sr <= bin;
            bcd_sr <= '0;
            cnt    <= '0;
          end
        end
        CONV_SHIFT: begin
          bcd_sr <= BCD_W'({bcd_adj, bin_sr[BIN_W-1]});
          bin_sr <= bin_sr << 1;
          cnt    <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != CONV_IDLE);
  assign done = (state == CONV_COMMIT);
  assign bcd  = bcd_sr;

endmodule

// File: rtl/seg_score_display.sv
// Score display driver: converts the score to BCD, then scans the digits onto
// common-anode 7-segment pins with blanking, blink and saturation.
module seg_score_display
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned SCORE_W     = 14,
  parameter logic [15:0] REFRESH_DIV = 16'd50000,
  parameter int unsigned BLINK_W     = 24
) (
  input  logic                  segclk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [SCORE_W-1:0]    score,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic                  blink,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  busy,
  output logic                  ovf
);

  localparam int unsigned DIV_W     = (REFRESH_DIV > 16'd1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [63:0] MAX_SCORE = 64'(10 ** NUM_DIGITS) - 64'd1;

  logic [4*NUM_DIGITS-1:0]     conv_bcd;
  logic                        conv_done;
  logic                        ovf_pending;
  logic [NUM_DIGITS-1:0][3:0]  digits;
  logic [DIV_W-1:0]            div;
  logic [IDX_W-1:0]            idx;
  logic [BLINK_W-1:0]          blink_cnt;
  logic                        upper_zero;
  logic                        slot_blank;
  logic                        dark;

  bin2bcd_seq #(
    .BIN_W      (SCORE_W),
    .OUT_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk   (segclk),
    .rst_n (reset_n),
    .load  (load),
    .bin   (score),
    .busy  (busy),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  // The overflow verdict is taken with the score and applied at commit time,
  // together with the digits, so the display never tears.
  always_ff @(posedge segclk) begin
    // NOTE: the digit registers are reset because a cleared display is
    // observable behaviour, not just initialisation convenience.
    if (!reset_n) begin
      ovf_pending <= 1'b0;
      ovf         <= 1'b0;
      digits      <= '0;
    end else begin
      if (load && !busy) ovf_pending <= (64'(score) > MAX_SCORE);
      if (conv_done) begin
        ovf    <= ovf_pending;
        digits <= ovf_pending ? {NUM_DIGITS{4'd9}} : conv_bcd;
      end
    end
  end

  always_ff @(posedge segclk) begin
    if (!reset_n) begin
      div       <= '0;
      idx       <= '0;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
      if (div == DIV_W'(REFRESH_DIV - 16'd1)) begin
        div <= '0;
        idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  always_comb begin
    upper_zero = 1'b1;
    for (int j = 0; j < int'(NUM_DIGITS); j++) begin
      if (j >= int'(idx) && digits[j] != 4'd0) upper_zero = 1'b0;
    end
    slot_blank = blank_lz && (idx != '0) && upper_zero;
    dark       = !start || (blink && blink_cnt[BLINK_W-1]);
  end

  always_ff @(posedge segclk) begin
    if (!reset_n) begin
      seg <= SEG_OFF;
      an  <= '1;
    end else if (dark || slot_blank) begin
      seg <= SEG_OFF;
      an  <= '1;
    end else begin
      seg <= seg_decode(digits[idx]);
      an  <= ~(NUM_DIGITS'(1) << idx);
    end
  end

endmodule

// File: tb/tb_seg_score_display.sv
// Directed bench for seg_score_display with a short refresh divider and a
// 4-bit blink counter so every behaviour is visible within a few hundred cycles.
module tb_seg_score_display;

  localparam logic [6:0] G0  = 7'b1000000;
  localparam logic [6:0] G1  = 7'b1111001;
  localparam logic [6:0] G2  = 7'b0100100;
  localparam logic [6:0] G4  = 7'b0011001;
  localparam logic [6:0] G5  = 7'b0010010;
  localparam logic [6:0] G6  = 7'b0000010;
  localparam logic [6:0] G9  = 7'b0010000;
  localparam logic [6:0] OFF = 7'h7F;

  logic        segclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] score = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        blink = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        busy;
  logic        ovf;

  int tests_run = 0;
  int tests_failed = 0;

  logic [6:0] seen_seg[4];
  int         lit_cnt[4];
  int         bad_cnt;
  logic [6:0] exp_seg[4];
  int         exp_lit[4];

  always #5 segclk = ~segclk;

  seg_score_display #(
    .NUM_DIGITS  (4),
    .SCORE_W     (14),
    .REFRESH_DIV (16'd4),
    .BLINK_W     (4)
  ) dut (
    .segclk   (segclk),
    .reset_n  (reset_n),
    .start    (start),
    .score    (score),
    .load     (load),
    .blank_lz (blank_lz),
    .blink    (blink),
    .seg      (seg),
    .an       (an),
    .busy     (busy),
    .ovf      (ovf)
  );

  task automatic tick;
    @(posedge segclk);
    #1;
  endtask

  // One full 16-cycle scan period: each slot should be lit exactly 4 samples
  // with a constant glyph, and dark samples must have all segments off.
  task automatic scan_window;
    int slot;
    for (int i = 0; i < 4; i++) begin
      seen_seg[i] = OFF;
      lit_cnt[i]  = 0;
    end
    bad_cnt = 0;
    repeat (16) begin
      tick();
      case (an)
        4'hE:    slot = 0;
        4'hD:    slot = 1;
        4'hB:    slot = 2;
        4'h7:    slot = 3;
        4'hF:    slot = -1;
        default: slot = -2;
      endcase
      if (slot >= 0) begin
        if (lit_cnt[slot] > 0 && seen_seg[slot] !== seg) bad_cnt++;
        seen_seg[slot] = seg;
        lit_cnt[slot]++;
      end else if (slot == -1) begin
        if (seg !== OFF) bad_cnt++;
      end else begin
        bad_cnt++;
      end
    end
  endtask

  task automatic do_load(input logic [13:0] value);
    score = value;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 64) begin
      cycles++;
      tick();
    end
  endtask

  task automatic test_reset;
    start = 1'b1;
    blank_lz = 1'b0;
    repeat (6) tick();
    reset_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if (seg !== OFF || an !== 4'hF || busy !== 1'b0 || ovf !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset cycle %0d: seg=%h an=%h busy=%b ovf=%b, expected 7f f 0 0",
                 c, seg, an, busy, ovf);
      end
    end
    reset_n = 1'b1;
    scan_window();
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (lit_cnt[i] !== 4 || seen_seg[i] !== G0) begin
        tests_failed++;
        $display("FAIL reset digits slot%0d: lit=%0d seg=%b, expected lit=4 seg=%b",
                 i, lit_cnt[i], seen_seg[i], G0);
      end
    end
  endtask

  task automatic test_convert;
    int cycles;
    blank_lz = 1'b1;
    do_load(14'd16);
    wait_idle(cycles);
    tests_run++;
    if (cycles !== 15) begin
      tests_failed++;
      $display("FAIL convert busy length: got %0d cycles, expected 15", cycles);
    end
    exp_seg = '{G6, G1, OFF, OFF};
    exp_lit = '{4, 4, 0, 0};
    scan_window();
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (lit_cnt[i] !== exp_lit[i] || (exp_lit[i] > 0 && seen_seg[i] !== exp_seg[i])) begin
        tests_failed++;
        $display("FAIL convert 16 slot%0d: lit=%0d seg=%b, expected lit=%0d seg=%b",
                 i, lit_cnt[i], seen_seg[i], exp_lit[i], exp_seg[i]);
      end
    end
    tests_run++;
    if (bad_cnt !== 0) begin
      tests_failed++;
      $display("FAIL convert 16 scan glitches: got %0d, expected 0", bad_cnt);
    end
  endtask

  task automatic test_zero_blank;
    int cycles;
    logic [13:0] vals[3];
    logic [6:0]  segs[3][4];
    int          lits[3][4];
    vals = '{14'd0, 14'd205, 14'd1009};
    segs = '{'{G0, OFF, OFF, OFF}, '{G5, G0, G2, OFF}, '{G9, G0, G0, G1}};
    lits = '{'{4, 0, 0, 0}, '{4, 4, 4, 0}, '{4, 4, 4, 4}};
    blank_lz = 1'b1;
    for (int v = 0; v < 3; v++) begin
      do_load(vals[v]);
      wait_idle(cycles);
      scan_window();
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (lit_cnt[i] !== lits[v][i] || (lits[v][i] > 0 && seen_seg[i] !== segs[v][i])) begin
          tests_failed++;
          $display("FAIL blanking %0d slot%0d: lit=%0d seg=%b, expected lit=%0d seg=%b",
                   vals[v], i, lit_cnt[i], seen_seg[i], lits[v][i], segs[v][i]);
        end
      end
    end
    blank_lz = 1'b0;
    do_load(14'd0);
    wait_idle(cycles);
    scan_window();
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (lit_cnt[i] !== 4 || seen_seg[i] !== G0) begin
        tests_failed++;
        $display("FAIL no-blank zero slot%0d: lit=%0d seg=%b, expected lit=4 seg=%b",
                 i, lit_cnt[i], seen_seg[i], G0);
      end
    end
    blank_lz = 1'b1;
  endtask

  task automatic test_overflow;
    int cycles;
    logic [13:0] vals[3];
    logic        ovfs[3];
    vals = '{14'd12345, 14'd9999, 14'd10000};
    ovfs = '{1'b1, 1'b0, 1'b1};
    do_load(vals[0]);
    repeat (14) tick();
    tests_run++;
    if (busy !== 1'b1 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL overflow before commit: busy=%b ovf=%b, expected 1 0", busy, ovf);
    end
    tick();
    tests_run++;
    if (busy !== 1'b0 || ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL overflow at commit: busy=%b ovf=%b, expected 0 1", busy, ovf);
    end
    for (int v = 0; v < 3; v++) begin
      if (v > 0) begin
        do_load(vals[v]);
        wait_idle(cycles);
      end
      tests_run++;
      if (ovf !== ovfs[v]) begin
        tests_failed++;
        $display("FAIL ovf flag %0d: got %b, expected %b", vals[v], ovf, ovfs[v]);
      end
      scan_window();
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (lit_cnt[i] !== 4 || seen_seg[i] !== G9) begin
          tests_failed++;
          $display("FAIL saturate %0d slot%0d: lit=%0d seg=%b, expected lit=4 seg=%b",
                   vals[v], i, lit_cnt[i], seen_seg[i], G9);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int cycles;
    blank_lz = 1'b1;
    do_load(14'd42);
    tick();
    tick();
    score = 14'd7;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    wait_idle(cycles);
    tests_run++;
    if (cycles + 3 !== 15) begin
      tests_failed++;
      $display("FAIL ignored load busy length: got %0d cycles, expected 15", cycles + 3);
    end
    exp_seg = '{G2, G4, OFF, OFF};
    exp_lit = '{4, 4, 0, 0};
    scan_window();
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (lit_cnt[i] !== exp_lit[i] || (exp_lit[i] > 0 && seen_seg[i] !== exp_seg[i])) begin
        tests_failed++;
        $display("FAIL ignored load 42 slot%0d: lit=%0d seg=%b, expected lit=%0d seg=%b",
                 i, lit_cnt[i], seen_seg[i], exp_lit[i], exp_seg[i]);
      end
    end
    tests_run++;
    if (busy !== 1'b0 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignored load not queued: busy=%b ovf=%b, expected 0 0", busy, ovf);
    end
  endtask

  task automatic test_dark;
    int  blink_bad;
    int  start_bad;
    bit  exp_dark;
    bit  is_dark;
    blank_lz = 1'b0;
    do_load(14'd16);
    repeat (3) tick();
    reset_n = 1'b0;
    blink   = 1'b1;
    tick();
    reset_n = 1'b1;
    tests_run++;
    if (busy !== 1'b0 || ovf !== 1'b0 || an !== 4'hF) begin
      tests_failed++;
      $display("FAIL reset in shift: busy=%b ovf=%b an=%h, expected 0 0 f", busy, ovf, an);
    end
    blink_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      exp_dark = (((k - 1) % 16) >= 8);
      is_dark  = (an === 4'hF) && (seg === OFF);
      if (is_dark !== exp_dark || (!exp_dark && an === 4'hF) || busy !== 1'b0) blink_bad++;
    end
    tests_run++;
    if (blink_bad !== 0) begin
      tests_failed++;
      $display("FAIL blink phase: %0d wrong samples, expected 0", blink_bad);
    end
    blink = 1'b0;
    scan_window();
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (lit_cnt[i] !== 4 || seen_seg[i] !== G0) begin
        tests_failed++;
        $display("FAIL aborted conversion slot%0d: lit=%0d seg=%b, expected lit=4 seg=%b",
                 i, lit_cnt[i], seen_seg[i], G0);
      end
    end
    start = 1'b0;
    start_bad = 0;
    repeat (20) begin
      tick();
      if (an !== 4'hF || seg !== OFF) start_bad++;
    end
    tests_run++;
    if (start_bad !== 0) begin
      tests_failed++;
      $display("FAIL start low dark: %0d lit samples, expected 0", start_bad);
    end
    start = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    test_reset();
    test_convert();
    test_zero_blank();
    test_overflow();
    test_back_to_back();
    test_dark();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
